// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: next-PC select encodings,
// the NOP encoding and the default PC vectors used by the fetch stage.
package cpu_pkg;

   // Next-PC select encodings driven by the control path.
   typedef enum logic [2:0] {
      PCSRC_SEQ   = 3'b000,
      PCSRC_BR    = 3'b001,
      PCSRC_J     = 3'b010,
      PCSRC_JR    = 3'b011,
      PCSRC_IRQ   = 3'b100,
      PCSRC_EXC   = 3'b101,
      PCSRC_RSVD6 = 3'b110,
      PCSRC_RSVD7 = 3'b111
   } pcsrc_e;

   // All-zero word is sll $0,$0,0, used as the bubble instruction.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Default vectors; the fetch stage exposes these as overridable parameters.
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_ILLOP_VECTOR = 32'h8000_0004;
   localparam logic [31:0] DEF_XADR_VECTOR  = 32'h8000_0008;

   // j/jal target: upper nibble of the delay-slot PC, 26-bit index, word aligned.
   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [31:0] instr);
      return {pc_plus4[31:28], instr[25:0], 2'b00};
   endfunction

endpackage

// File: rtl/if2id_reg.sv
// IF/ID pipeline register. Flush has priority over write; with neither
// asserted the register holds. Reset (active-low, synchronous) inserts a bubble.
module if2id_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        write,
   input  logic [31:0] fetch_instr,
   input  logic [31:0] fetch_pc_plus4,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   logic [31:0] instr_reg;
   logic [31:0] pc_plus4_reg;
   logic        valid_reg;

   // Capture the fetched word, or replace it with a bubble on flush/reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_reg    <= NOP_INSTR;
         pc_plus4_reg <= 32'h0000_0000;
         valid_reg    <= 1'b0;
      end else if (flush) begin
         instr_reg    <= NOP_INSTR;
         pc_plus4_reg <= 32'h0000_0000;
         valid_reg    <= 1'b0;
      end else if (write) begin
         instr_reg    <= fetch_instr;
         pc_plus4_reg <= fetch_pc_plus4;
         valid_reg    <= 1'b1;
      end
   end

   assign instr    = instr_reg;
   assign pc_plus4 = pc_plus4_reg;
   assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID register of the 5-stage MIPS core.
// Owns the PC, selects the next PC from the redirect controls and hands the
// fetched instruction to ID through if2id_reg.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] ILLOP_VECTOR = DEF_ILLOP_VECTOR,
   parameter logic [31:0] XADR_VECTOR  = DEF_XADR_VECTOR
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  PCSrc,
   input  logic        Branch,
   input  logic [31:0] branch_target,
   input  logic [31:0] jr_target,
   input  logic        Write_PC,
   input  logic        Write_IF2ID,
   input  logic        flush_IF2ID,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] IF2ID_instr,
   output logic [31:0] IF2ID_pc_plus4,
   output logic        IF2ID_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   logic [31:0] pc_reg;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic        redirect;

   assign pc_plus4 = pc_reg + 32'd4;

   // Next-PC mux; redirect marks any control transfer that must not be lost to a stall.
   always_comb begin
      pc_next  = pc_plus4;
      redirect = 1'b0;
      case (PCSrc)
         PCSRC_BR: begin
            if (Branch) begin
               pc_next  = branch_target;
               redirect = 1'b1;
            end
         end
         PCSRC_J: begin
            pc_next  = jump_target(IF2ID_pc_plus4, IF2ID_instr);
            redirect = 1'b1;
         end
         PCSRC_JR: begin
            pc_next  = jr_target & 32'hFFFF_FFFC;
            redirect = 1'b1;
         end
         PCSRC_IRQ: begin
            pc_next  = ILLOP_VECTOR;
            redirect = 1'b1;
         end
         PCSRC_EXC: begin
            pc_next  = XADR_VECTOR;
            redirect = 1'b1;
         end
         default: begin
            pc_next  = pc_plus4;
            redirect = 1'b0;
         end
      endcase
   end

   // PC register: a redirect loads even during a load-use stall.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg <= RESET_VECTOR;
      end else if (Write_PC || redirect) begin
         pc_reg <= pc_next;
      end
   end

   assign pc        = pc_reg;
   assign imem_addr = pc_reg;

   if2id_reg u_if2id (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush_IF2ID),
      .write          (Write_IF2ID),
      .fetch_instr    (imem_rdata),
      .fetch_pc_plus4 (pc_plus4),
      .instr          (IF2ID_instr),
      .pc_plus4       (IF2ID_pc_plus4),
      .valid          (IF2ID_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;
   logic [31:0] flush_cnt_reg;

   // Saturating counters of IF/ID hold cycles and IF/ID flush cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_reg <= 32'h0000_0000;
         flush_cnt_reg <= 32'h0000_0000;
      end else begin
         if (!Write_IF2ID && !flush_IF2ID && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
         if (flush_IF2ID && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
            flush_cnt_reg <= flush_cnt_reg + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID and PC state is queued when
// each cycle's stimulus is applied and compared after the clock edge.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [2:0]  PCSrc;
   logic        Branch;
   logic [31:0] branch_target;
   logic [31:0] jr_target;
   logic        Write_PC;
   logic        Write_IF2ID;
   logic        flush_IF2ID;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] IF2ID_instr;
   logic [31:0] IF2ID_pc_plus4;
   logic        IF2ID_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] m_stall;
   logic [31:0] m_flush;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] stall;
      logic [31:0] flush;
`endif
   } exp_t;

   exp_t sb[$];

   // model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .PCSrc          (PCSrc),
      .Branch         (Branch),
      .branch_target  (branch_target),
      .jr_target      (jr_target),
      .Write_PC       (Write_PC),
      .Write_IF2ID    (Write_IF2ID),
      .flush_IF2ID    (flush_IF2ID),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .pc             (pc),
      .IF2ID_instr    (IF2ID_instr),
      .IF2ID_pc_plus4 (IF2ID_pc_plus4),
      .IF2ID_valid    (IF2ID_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction ROM contents: two fixed words, a pattern elsewhere.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h2008_0005;
      if (a == 32'h9000_0004) return 32'h0800_0010;
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   always_comb imem_rdata = imem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply current inputs for one clock, queue the expected result, then compare.
   task automatic cycle(input string tag);
      exp_t        e;
      logic [31:0] p4;
      logic [31:0] np;
      logic        redir;
      p4    = m_pc + 32'd4;
      np    = p4;
      redir = 1'b0;
      if (PCSrc == 3'b001 && Branch) begin np = branch_target; redir = 1'b1; end
      if (PCSrc == 3'b010) begin np = {m_pc4[31:28], m_instr[25:0], 2'b00}; redir = 1'b1; end
      if (PCSrc == 3'b011) begin np = {jr_target[31:2], 2'b00}; redir = 1'b1; end
      if (PCSrc == 3'b100) begin np = 32'h8000_0004; redir = 1'b1; end
      if (PCSrc == 3'b101) begin np = 32'h8000_0008; redir = 1'b1; end
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
`ifdef FETCH_PERF_CNT_EN
      e.stall = m_stall; e.flush = m_flush;
`endif
      if (!reset) begin
         e.pc = 32'h0; e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
         e.stall = 32'h0; e.flush = 32'h0;
`endif
      end else begin
         if (Write_PC || redir) e.pc = np;
         if (flush_IF2ID) begin
            e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
         end else if (Write_IF2ID) begin
            e.instr = imem_word(m_pc); e.pc4 = p4; e.valid = 1'b1;
         end
`ifdef FETCH_PERF_CNT_EN
         if (!Write_IF2ID && !flush_IF2ID && m_stall != 32'hFFFF_FFFF) e.stall = m_stall + 1;
         if (flush_IF2ID && m_flush != 32'hFFFF_FFFF) e.flush = m_flush + 1;
`endif
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".imem_addr"}, imem_addr, e.pc);
      chk({tag, ".instr"}, IF2ID_instr, e.instr);
      chk({tag, ".pc4"}, IF2ID_pc_plus4, e.pc4);
      chk({tag, ".valid"}, {31'h0, IF2ID_valid}, {31'h0, e.valid});
`ifdef FETCH_PERF_CNT_EN
      chk({tag, ".stall_cnt"}, stall_cnt, e.stall);
      chk({tag, ".flush_cnt"}, flush_cnt, e.flush);
      m_stall = e.stall; m_flush = e.flush;
`endif
      $display("cycle %-10s pc=%h instr=%h pc4=%h valid=%0d", tag, pc, IF2ID_instr,
               IF2ID_pc_plus4, IF2ID_valid);
      m_pc = e.pc; m_instr = e.instr; m_pc4 = e.pc4; m_valid = e.valid;
   endtask

   task automatic defaults();
      PCSrc = 3'b000; Branch = 1'b0; branch_target = 32'h0; jr_target = 32'h0;
      Write_PC = 1'b1; Write_IF2ID = 1'b1; flush_IF2ID = 1'b0;
   endtask

   initial begin
      m_pc = 32'hxxxx_xxxx; m_instr = 32'hxxxx_xxxx; m_pc4 = 32'hxxxx_xxxx; m_valid = 1'bx;
`ifdef FETCH_PERF_CNT_EN
      m_stall = 32'hxxxx_xxxx; m_flush = 32'hxxxx_xxxx;
`endif
      defaults();
      reset = 1'b0;
      // reset held three cycles
      cycle("rst0"); cycle("rst1"); cycle("rst2");
      chk("rst.pc", pc, 32'h0000_0000);
      chk("rst.valid", {31'h0, IF2ID_valid}, 32'h0);

      // release: first fetch at 0 lands in IF/ID
      reset = 1'b1;
      cycle("rel");
      chk("rel.pc", pc, 32'h0000_0004);
      chk("rel.instr", IF2ID_instr, 32'h2008_0005);
      chk("rel.pc4", IF2ID_pc_plus4, 32'h0000_0004);
      chk("rel.valid", {31'h0, IF2ID_valid}, 32'h1);
      cycle("seq8");
      chk("seq8.pc", pc, 32'h0000_0008);
      cycle("seqC"); cycle("seq10");

      // load-use stall at pc=0x10
      Write_PC = 1'b0; Write_IF2ID = 1'b0;
      cycle("stall");
      chk("stall.pc", pc, 32'h0000_0010);
      chk("stall.instr", IF2ID_instr, imem_word(32'h0000_000C));
      defaults();
      cycle("resume");
      chk("resume.pc", pc, 32'h0000_0014);

      // taken branch with flush
      PCSrc = 3'b001; Branch = 1'b1; branch_target = 32'h40; flush_IF2ID = 1'b1;
      cycle("br_t");
      chk("br_t.pc", pc, 32'h0000_0040);
      chk("br_t.instr", IF2ID_instr, 32'h0);
      // not-taken branch
      Branch = 1'b0; flush_IF2ID = 1'b0;
      cycle("br_nt");
      chk("br_nt.pc", pc, 32'h0000_0044);
      chk("br_nt.valid", {31'h0, IF2ID_valid}, 32'h1);

      // taken branch during load-use stall
      Branch = 1'b1; flush_IF2ID = 1'b1; Write_PC = 1'b0; Write_IF2ID = 1'b0;
      cycle("br_lu");
      chk("br_lu.pc", pc, 32'h0000_0040);
      chk("br_lu.valid", {31'h0, IF2ID_valid}, 32'h0);

      // place j 0x10 in IF/ID with pc_plus4=0x9000_0008
      defaults();
      PCSrc = 3'b001; Branch = 1'b1; branch_target = 32'h9000_0004; flush_IF2ID = 1'b1;
      cycle("br_9");
      defaults();
      cycle("fetch_j");
      chk("fetch_j.instr", IF2ID_instr, 32'h0800_0010);
      chk("fetch_j.pc4", IF2ID_pc_plus4, 32'h9000_0008);
      PCSrc = 3'b010; flush_IF2ID = 1'b1;
      cycle("jump");
      chk("jump.pc", pc, 32'h9000_0040);
      defaults();
      PCSrc = 3'b011; jr_target = 32'h0000_0123;
      cycle("jr");
      chk("jr.pc", pc, 32'h0000_0120);

      // wrap at top of address space
      defaults();
      PCSrc = 3'b001; Branch = 1'b1; branch_target = 32'hFFFF_FFFC;
      cycle("br_top");
      defaults();
      cycle("wrap");
      chk("wrap.pc", pc, 32'h0000_0000);
      chk("wrap.pc4", IF2ID_pc_plus4, 32'h0000_0000);

      // interrupt, exception, reserved encoding
      PCSrc = 3'b100;
      cycle("irq");
      chk("irq.pc", pc, 32'h8000_0004);
      PCSrc = 3'b101;
      cycle("exc");
      chk("exc.pc", pc, 32'h8000_0008);
      PCSrc = 3'b110;
      cycle("rsvd");
      chk("rsvd.pc", pc, 32'h8000_000C);

      // flush wins over a stalled IF/ID
      defaults();
      Write_PC = 1'b0; Write_IF2ID = 1'b0; flush_IF2ID = 1'b1;
      cycle("fl_stall");
      chk("fl_stall.valid", {31'h0, IF2ID_valid}, 32'h0);
      defaults();
      cycle("refill");

      // reset during a stall
      Write_PC = 1'b0; Write_IF2ID = 1'b0; reset = 1'b0;
      cycle("rst_st");
      chk("rst_st.pc", pc, 32'h0000_0000);
      chk("rst_st.valid", {31'h0, IF2ID_valid}, 32'h0);
      defaults();
      reset = 1'b1;
      cycle("rel2");
      chk("rel2.instr", IF2ID_instr, 32'h2008_0005);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS core; sits directly downstream of the hazard unit.
- Consumes the hazard unit's Write_PC, Write_IF2ID and flush_IF2ID, and the PCSrc/Branch redirect controls.
- Owns the PC, drives the instruction-memory address and captures the instruction into the IF/ID register for the ID stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
ILLOP_VECTOR, 32'h8000_0004, interrupt entry address (PCSrc=100)
XADR_VECTOR, 32'h8000_0008, exception entry address (PCSrc=101)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous reset, active-low; sampled on rising edge of clk
PCSrc  input  3  next-PC select: 000 seq, 001 branch, 010 j/jal, 011 jr/jalr, 100 interrupt, 101 exception
Branch  input  1  branch condition true (qualifies PCSrc=001)
branch_target  input  32  branch target computed in EX
jr_target  input  32  register value for jr/jalr from ID
Write_PC  input  1  PC write enable from hazard unit (0 = load-use stall)
Write_IF2ID  input  1  IF/ID write enable from hazard unit
flush_IF2ID  input  1  IF/ID flush from hazard unit
imem_addr  output  32  instruction memory address (= pc)
imem_rdata  input  32  instruction word, combinational read of imem_addr
pc  output  32  current PC
IF2ID_instr  output  32  instruction held for ID
IF2ID_pc_plus4  output  32  PC+4 of held instruction
IF2ID_valid  output  1  held instruction is real (not a bubble)

Behaviour:
- Reset (reset=0 at clock edge): pc<=RESET_VECTOR; IF2ID_instr<=0 (NOP); IF2ID_pc_plus4<=0; IF2ID_valid<=0. Reset overrides all other inputs, including mid-stall and mid-flush.
- Reset release: first fetch at RESET_VECTOR; its instruction appears on IF2ID_* one cycle later.
- pc_plus4 = pc+4, modulo 2^32. 0xFFFF_FFFC wraps to 0.
- next_pc selection:
  - 000 -> pc_plus4.
  - 001 -> branch_target if Branch, else pc_plus4.
  - 010 -> {IF2ID_pc_plus4[31:28], IF2ID_instr[25:0], 2'b00}.
  - 011 -> {jr_target[31:2], 2'b00}.
  - 100 -> ILLOP_VECTOR.
  - 101 -> XADR_VECTOR.
  - 110/111 -> pc_plus4 (reserved).
- redirect = (PCSrc=001 & Branch) | PCSrc in {010,011,100,101}.
- PC update: pc<=next_pc when Write_PC | redirect; otherwise hold.
  - A redirect overrides a simultaneous load-use stall so the target is not lost.
- IF/ID update priority: flush_IF2ID > Write_IF2ID.
  - Flush: instr<=0, pc_plus4<=0, valid<=0.
  - Write (no flush): instr<=imem_rdata, pc_plus4<=pc_plus4, valid<=1.
  - Neither: hold all three.
- flush_IF2ID with Write_IF2ID=0 in the same cycle: flush wins.
- Latency: one cycle from PC to IF/ID. Redirect costs one bubble in IF/ID for ID-resolved jumps; branch-flush count is set by the hazard unit.
- No handshake with memory; imem is a zero-wait combinational ROM.

Optional Feature:
- Macro FETCH_PERF_CNT_EN. When defined, adds:
  - stall_cnt (output, 32): increments each cycle Write_IF2ID=0 and flush_IF2ID=0.
  - flush_cnt (output, 32): increments each cycle flush_IF2ID=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_IRQ, PCSRC_EXC).
  - NOP_INSTR = 32'h0.
  - Default vector constants.
- One sub-module, if2id_reg: the IF/ID register with flush/write priority, reusable pattern for later stage registers.
- next-PC mux stays inline.

Test Plan:
- Reset held 3 cycles then released, imem[0]=0x2008_0005 -> pc=0,4,8; cycle 2 IF2ID_instr=0x2008_0005, pc_plus4=4, valid=1.
- Write_PC=0, Write_IF2ID=0 for 1 cycle at pc=0x10 -> pc stays 0x10; IF2ID holds prior instr; next cycle resumes at 0x14.
- PCSrc=001, Branch=1, branch_target=0x40, flush_IF2ID=1 -> pc=0x40 next cycle; IF2ID instr=0, valid=0.
  - Same stimulus with Branch=0 -> pc=pc+4, no flush.
- Branch redirect with simultaneous Write_PC=0, Write_IF2ID=0 (load-use) -> pc still loads 0x40; IF2ID flushed.
- IF2ID holds j 0x0000010 (instr=0x0800_0010, pc_plus4=0x9000_0008), PCSrc=010 -> pc=0x9000_0040.
  - PCSrc=011, jr_target=0x0000_0123 -> pc=0x0000_0120.
- pc=0xFFFF_FFFC sequential -> pc wraps to 0.
  - PCSrc=101 -> pc=0x8000_0008.
  - reset=0 asserted during a stall -> pc=RESET_VECTOR, valid=0.
